// File: rtl/mps_multicycle_cpu.sv
// Multi-cycle MIPS-subset CPU with one unified req/ready memory port and an internal register file.
// Each instruction walks IDLE/FETCH/DECODE/EXEC/MEM/WB; illegal opcodes or misaligned accesses park it in HALT.
module mps_multicycle_cpu #(
  parameter logic [31:0] RESET_PC    = 32'h0000_0000,
  parameter bit          ALIGN_CHECK = 1'b1
) (
  input  logic        clock,
  input  logic        nreset,
  output logic        mem_req,
  output logic        mem_write,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  input  logic [31:0] mem_rdata,
  input  logic        mem_ready,
  output logic [31:0] pc,
  output logic        retire,
  output logic        halted
);

  typedef enum logic [2:0] {
    S_IDLE, S_FETCH, S_DECODE, S_EXEC, S_MEM, S_WB, S_HALT
  } state_t;

  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_J     = 6'h02;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_BNE   = 6'h05;
  localparam logic [5:0] OP_ADDI  = 6'h08;
  localparam logic [5:0] OP_ADDIU = 6'h09;
  localparam logic [5:0] OP_ANDI  = 6'h0c;
  localparam logic [5:0] OP_ORI   = 6'h0d;
  localparam logic [5:0] OP_LUI   = 6'h0f;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2b;

  localparam logic [5:0] F_ADD  = 6'h20;
  localparam logic [5:0] F_ADDU = 6'h21;
  localparam logic [5:0] F_SUB  = 6'h22;
  localparam logic [5:0] F_SUBU = 6'h23;
  localparam logic [5:0] F_AND  = 6'h24;
  localparam logic [5:0] F_OR   = 6'h25;
  localparam logic [5:0] F_XOR  = 6'h26;
  localparam logic [5:0] F_NOR  = 6'h27;
  localparam logic [5:0] F_SLT  = 6'h2a;
  localparam logic [5:0] F_SLTU = 6'h2b;

  state_t      state, state_nxt;
  logic [31:0] ir, rs_q, rt_q, imm_q, alu_q, mdr;
  logic [31:0] regs [32];

  logic [5:0]  op, funct;
  logic [4:0]  rs_idx, rt_idx, rd_idx, wb_idx;
  logic [31:0] imm_ext, alu_res;
  logic        legal, is_mem_op, misalign, branch_taken;

  assign op     = ir[31:26];
  assign rs_idx = ir[25:21];
  assign rt_idx = ir[20:16];
  assign rd_idx = ir[15:11];
  assign funct  = ir[5:0];
  assign wb_idx = (op == OP_RTYPE) ? rd_idx : rt_idx;

  assign is_mem_op    = (op == OP_LW) || (op == OP_SW);
  assign misalign     = ALIGN_CHECK && is_mem_op && (alu_res[1:0] != 2'b00);
  assign branch_taken = ((op == OP_BEQ) && (rs_q == rt_q)) ||
                        ((op == OP_BNE) && (rs_q != rt_q));
  assign mem_wdata    = rt_q;

  // NOTE: every signal written in an always_comb gets a default first, otherwise a latch is inferred.
  always_comb begin
    legal = 1'b0;
    case (op)
      OP_RTYPE: legal = funct inside {F_ADD, F_ADDU, F_SUB, F_SUBU, F_AND,
                                      F_OR, F_XOR, F_NOR, F_SLT, F_SLTU};
      OP_J, OP_BEQ, OP_BNE, OP_ADDI, OP_ADDIU,
      OP_ANDI, OP_ORI, OP_LUI, OP_LW, OP_SW: legal = 1'b1;
      default: legal = 1'b0;
    endcase
  end

  // andi/ori zero-extend, lui pre-shifts; everything else sign-extends
  always_comb begin
    imm_ext = {{16{ir[15]}}, ir[15:0]};
    case (op)
      OP_ANDI, OP_ORI: imm_ext = {16'h0000, ir[15:0]};
      OP_LUI:          imm_ext = {ir[15:0], 16'h0000};
      default:         imm_ext = {{16{ir[15]}}, ir[15:0]};
    endcase
  end

  always_comb begin
    alu_res = '0;
    if (op == OP_RTYPE) begin
      case (funct)
        F_ADD, F_ADDU: alu_res = rs_q + rt_q;
        F_SUB, F_SUBU: alu_res = rs_q - rt_q;
        F_AND:         alu_res = rs_q & rt_q;
        F_OR:          alu_res = rs_q | rt_q;
        F_XOR:         alu_res = rs_q ^ rt_q;
        F_NOR:         alu_res = ~(rs_q | rt_q);
        F_SLT:         alu_res = {31'd0, $signed(rs_q) < $signed(rt_q)};
        F_SLTU:        alu_res = {31'd0, rs_q < rt_q};
        default:       alu_res = '0;
      endcase
    end else begin
      case (op)
        OP_ANDI: alu_res = rs_q & imm_q;
        OP_ORI:  alu_res = rs_q | imm_q;
        OP_LUI:  alu_res = imm_q;
        default: alu_res = rs_q + imm_q;
      endcase
    end
  end

  // NOTE: sequential state is assigned with non-blocking <= so every flop samples pre-edge values.
  always_ff @(posedge clock or negedge nreset) begin
    if (!nreset) state <= S_IDLE;
    else         state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    mem_req   = 1'b0;
    mem_write = 1'b0;
    mem_addr  = pc;
    retire    = 1'b0;
    halted    = 1'b0;
    case (state)
      S_IDLE:   state_nxt = S_FETCH;
      S_FETCH: begin
        mem_req = 1'b1;
        if (mem_ready) state_nxt = S_DECODE;
      end
      S_DECODE: state_nxt = legal ? S_EXEC : S_HALT;
      S_EXEC: begin
        if ((op == OP_BEQ) || (op == OP_BNE) || (op == OP_J)) begin
          retire    = 1'b1;
          state_nxt = S_FETCH;
        end else if (is_mem_op) begin
          state_nxt = misalign ? S_HALT : S_MEM;
        end else begin
          state_nxt = S_WB;
        end
      end
      S_MEM: begin
        mem_req   = 1'b1;
        mem_write = (op == OP_SW);
        mem_addr  = alu_q;
        if (mem_ready) begin
          retire    = (op == OP_SW);
          state_nxt = (op == OP_SW) ? S_FETCH : S_WB;
        end
      end
      S_WB: begin
        retire    = 1'b1;
        state_nxt = S_FETCH;
      end
      S_HALT:   halted = 1'b1;
      default:  state_nxt = S_IDLE;
    endcase
  end

  // NOTE: the register file is reset, so it must map to flops rather than a RAM macro.
  always_ff @(posedge clock or negedge nreset) begin
    if (!nreset) begin
      pc    <= RESET_PC;
      ir    <= '0;
      rs_q  <= '0;
      rt_q  <= '0;
      imm_q <= '0;
      alu_q <= '0;
      mdr   <= '0;
      for (int i = 0; i < 32; i++) regs[i] <= '0;
    end else begin
      case (state)
        S_FETCH: begin
          if (mem_ready) begin
            ir <= mem_rdata;
            pc <= pc + 32'd4;
          end
        end
        S_DECODE: begin
          rs_q  <= regs[rs_idx];
          rt_q  <= regs[rt_idx];
          imm_q <= imm_ext;
        end
        S_EXEC: begin
          alu_q <= alu_res;
          // pc already points past the branch, so the offset is relative to pc_old+4
          if (branch_taken)    pc <= pc + (imm_q << 2);
          else if (op == OP_J) pc <= {pc[31:28], ir[25:0], 2'b00};
        end
        S_MEM: begin
          if (mem_ready && (op == OP_LW)) mdr <= mem_rdata;
        end
        S_WB: begin
          // regs[0] is never written, so it keeps reading zero
          if (wb_idx != 5'd0) regs[wb_idx] <= (op == OP_LW) ? mdr : alu_q;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_mps_multicycle_cpu.sv
// Self-checking bench for mps_multicycle_cpu: vector tables, multi-cycle corner sequences and
// randomized programs compared against an instruction-level reference model.
`timescale 1ns/1ps
module tb_mps_multicycle_cpu;

  localparam logic [5:0] OP_J = 6'h02, OP_BEQ = 6'h04, OP_BNE = 6'h05, OP_ADDI = 6'h08,
                         OP_ADDIU = 6'h09, OP_ANDI = 6'h0c, OP_ORI = 6'h0d, OP_LUI = 6'h0f,
                         OP_LW = 6'h23, OP_SW = 6'h2b;
  localparam logic [5:0] FNS [10] = '{6'h20, 6'h21, 6'h22, 6'h23, 6'h24,
                                      6'h25, 6'h26, 6'h27, 6'h2a, 6'h2b};
  localparam logic [31:0] HALT_INSTR = 32'hFC00_0000;

  logic        clock = 1'b0;
  logic        nreset = 1'b0;
  logic        mem_req, mem_write, mem_ready, retire, halted;
  logic [31:0] mem_addr, mem_wdata, mem_rdata, pc;
  logic        mem_req2, mem_write2, mem_ready2, retire2, halted2;
  logic [31:0] mem_addr2, mem_wdata2, mem_rdata2, pc2;

  always #5 clock = ~clock;

  mps_multicycle_cpu #(.RESET_PC(32'h0), .ALIGN_CHECK(1'b1)) dut (
    .clock(clock), .nreset(nreset), .mem_req(mem_req), .mem_write(mem_write),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata),
    .mem_ready(mem_ready), .pc(pc), .retire(retire), .halted(halted));

  // Unaligned accesses pass through on this instance
  mps_multicycle_cpu #(.RESET_PC(32'h0), .ALIGN_CHECK(1'b0)) dut_na (
    .clock(clock), .nreset(nreset), .mem_req(mem_req2), .mem_write(mem_write2),
    .mem_addr(mem_addr2), .mem_wdata(mem_wdata2), .mem_rdata(mem_rdata2),
    .mem_ready(mem_ready2), .pc(pc2), .retire(retire2), .halted(halted2));

  logic [31:0] mem [1024];
  logic [31:0] mm  [1024];
  logic [31:0] mr  [32];
  logic [31:0] prog [$];
  logic [31:0] reads [$];
  logic [31:0] reads2 [$];
  logic [31:0] st_addr_q [$];
  logic [31:0] st_data_q [$];
  int          retire_cyc [$];
  int          wait_cycles, wcnt, cyc, retire_cnt, last_retire, req_cycles;
  int          n_checks, n_fail;

  typedef struct {
    logic [31:0] instr;
    logic [4:0]  rd;
    logic [31:0] exp;
  } vec_t;

  typedef struct {
    logic [31:0] instr;
    logic [31:0] next_addr;
  } cf_t;

  function automatic logic [31:0] r_op(input logic [5:0] fn, input int rd, input int rs, input int rt);
    return {6'h00, 5'(rs), 5'(rt), 5'(rd), 5'd0, fn};
  endfunction

  function automatic logic [31:0] i_op(input logic [5:0] op, input int rt, input int rs, input logic [15:0] imm);
    return {op, 5'(rs), 5'(rt), imm};
  endfunction

  function automatic logic [31:0] j_op(input logic [25:0] target);
    return {OP_J, target};
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Memory responder: fixed wait_cycles per transaction, garbage read data while not ready
  initial begin
    mem_ready = 1'b1; mem_rdata = '0; mem_ready2 = 1'b1; mem_rdata2 = '0;
    wcnt = 0; cyc = 0; retire_cnt = 0; last_retire = 0; req_cycles = 0;
    forever begin
      @(negedge clock);
      if (!nreset) begin
        wcnt = 0; mem_ready = 1'b1;
      end else if (mem_req) begin
        if (wcnt < wait_cycles) begin
          mem_ready = 1'b0; wcnt++; mem_rdata = $urandom;
        end else begin
          mem_ready = 1'b1; wcnt = 0;
          if (mem_write) begin
            mem[mem_addr[11:2]] = mem_wdata;
            st_addr_q.push_back(mem_addr);
            st_data_q.push_back(mem_wdata);
            mem_rdata = $urandom;
          end else begin
            mem_rdata = mem[mem_addr[11:2]];
            reads.push_back(mem_addr);
          end
        end
      end else begin
        mem_ready = 1'b1; wcnt = 0; mem_rdata = $urandom;
      end
      mem_rdata2 = mem[mem_addr2[11:2]];
      if (nreset && mem_req2) reads2.push_back(mem_addr2);
      #1;
      if (!nreset) begin
        cyc = 0; retire_cnt = 0; last_retire = 0;
      end else begin
        cyc++;
        if (mem_req) req_cycles++;
        if (retire) begin
          retire_cnt++; last_retire = cyc; retire_cyc.push_back(cyc);
        end
      end
    end
  end

  task automatic load_prog(input bit rand_data);
    for (int i = 0; i < 1024; i++) mem[i] = '0;
    foreach (prog[i]) mem[i] = prog[i];
    if (rand_data) for (int w = 'h180; w < 'h1C0; w++) mem[w] = $urandom;
    for (int i = 0; i < 1024; i++) mm[i] = mem[i];
  endtask

  task automatic start_cpu();
    nreset = 1'b0;
    reads.delete(); reads2.delete(); retire_cyc.delete();
    st_addr_q.delete(); st_data_q.delete(); req_cycles = 0;
    repeat (2) @(posedge clock);
    #2 nreset = 1'b1;
  endtask

  task automatic run_to_halt(input int budget, input string tag);
    int n = 0;
    while (!halted && n < budget) begin
      @(negedge clock);
      n++;
    end
    #2 check({tag, "_halted"}, halted, 1'b1);
  endtask

  // Instruction-level reference: executes mm/mr and accumulates the cycle cost of each instruction
  task automatic run_model(input int w, output int n_ret, output int cyc_sum);
    logic [31:0] pc_m, ins, a, b, se, ze, res, ea;
    logic [4:0]  dst;
    bit          done, wr;
    int          lat;
    pc_m = '0; n_ret = 0; cyc_sum = 0; done = 1'b0;
    for (int k = 0; k < 32; k++) mr[k] = '0;
    for (int step = 0; step < 2000 && !done; step++) begin
      ins = mm[pc_m[11:2]];
      a = mr[ins[25:21]]; b = mr[ins[20:16]];
      se = {{16{ins[15]}}, ins[15:0]}; ze = {16'h0, ins[15:0]};
      ea = a + se;
      pc_m = pc_m + 4; wr = 1'b1; dst = ins[20:16]; res = '0; lat = 4 + w;
      case (ins[31:26])
        6'h00: begin
          dst = ins[15:11];
          case (ins[5:0])
            6'h20, 6'h21: res = a + b;
            6'h22, 6'h23: res = a - b;
            6'h24: res = a & b;
            6'h25: res = a | b;
            6'h26: res = a ^ b;
            6'h27: res = ~(a | b);
            6'h2a: res = ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
            6'h2b: res = (a < b) ? 32'd1 : 32'd0;
            default: done = 1'b1;
          endcase
        end
        OP_ADDI, OP_ADDIU: res = a + se;
        OP_ANDI: res = a & ze;
        OP_ORI:  res = a | ze;
        OP_LUI:  res = {ins[15:0], 16'h0};
        OP_LW: begin res = mm[ea[11:2]]; lat = 5 + 2 * w; end
        OP_SW: begin mm[ea[11:2]] = b; wr = 1'b0; lat = 4 + 2 * w; end
        OP_BEQ: begin wr = 1'b0; lat = 3 + w; if (a == b) pc_m = pc_m + (se << 2); end
        OP_BNE: begin wr = 1'b0; lat = 3 + w; if (a != b) pc_m = pc_m + (se << 2); end
        OP_J: begin wr = 1'b0; lat = 3 + w; pc_m = {pc_m[31:28], ins[25:0], 2'b00}; end
        default: done = 1'b1;
      endcase
      if (!done) begin
        n_ret++; cyc_sum += lat;
        if (wr && dst != 5'd0) mr[dst] = res;
      end
    end
  endtask

  task automatic gen_random(input int n);
    prog.delete();
    for (int i = 0; i < n; i++) begin
      int kind, rd, rs, rt, lim, off;
      logic [15:0] imm, dofs;
      kind = $urandom_range(0, 9);
      rd = $urandom_range(0, 31); rs = $urandom_range(0, 31); rt = $urandom_range(0, 31);
      lim = (n - 1 - i) < 3 ? (n - 1 - i) : 3;
      off = $urandom_range(0, lim);
      imm = 16'($urandom);
      dofs = 16'(32'h600 + 4 * $urandom_range(0, 63));
      case (kind)
        0, 1, 2: prog.push_back(r_op(FNS[$urandom_range(0, 9)], rd, rs, rt));
        3: prog.push_back(i_op($urandom_range(0, 1) ? OP_ADDI : OP_ADDIU, rt, rs, imm));
        4: prog.push_back(i_op($urandom_range(0, 1) ? OP_ANDI : OP_ORI, rt, rs, imm));
        5: prog.push_back(i_op(OP_LUI, rt, 0, imm));
        6: prog.push_back(i_op(OP_SW, rt, 0, dofs));
        7: prog.push_back(i_op(OP_LW, rt, 0, dofs));
        8: prog.push_back(i_op($urandom_range(0, 1) ? OP_BEQ : OP_BNE, rt % 4, rs % 4, 16'(off)));
        default: prog.push_back(j_op(26'(i + 1 + off)));
      endcase
    end
    for (int k = 1; k < 32; k++) prog.push_back(i_op(OP_SW, k, 0, 16'(32'h800 + 4 * k)));
    prog.push_back(HALT_INSTR);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t vecs [21];
    cf_t  cfs [3];
    int   n_ret, cyc_sum, rc, bad;
    logic [31:0] pc_snap;

    n_checks = 0; n_fail = 0; wait_cycles = 0;

    vecs[0]  = '{i_op(OP_ADDI, 1, 0, 16'hFFFB),  5'd1,  32'hFFFF_FFFB};
    vecs[1]  = '{i_op(OP_LUI, 2, 0, 16'h1234),   5'd2,  32'h1234_0000};
    vecs[2]  = '{i_op(OP_ORI, 2, 2, 16'h5678),   5'd2,  32'h1234_5678};
    vecs[3]  = '{r_op(6'h2a, 3, 1, 0),           5'd3,  32'h0000_0001};
    vecs[4]  = '{r_op(6'h2b, 4, 1, 0),           5'd4,  32'h0000_0000};
    vecs[5]  = '{r_op(6'h20, 5, 1, 2),           5'd5,  32'h1234_5673};
    vecs[6]  = '{r_op(6'h22, 6, 0, 1),           5'd6,  32'h0000_0005};
    vecs[7]  = '{r_op(6'h23, 7, 1, 2),           5'd7,  32'hEDCB_A983};
    vecs[8]  = '{r_op(6'h24, 8, 1, 2),           5'd8,  32'h1234_5678};
    vecs[9]  = '{r_op(6'h25, 9, 1, 2),           5'd9,  32'hFFFF_FFFB};
    vecs[10] = '{r_op(6'h26, 10, 1, 2),          5'd10, 32'hEDCB_A983};
    vecs[11] = '{r_op(6'h27, 11, 1, 0),          5'd11, 32'h0000_0004};
    vecs[12] = '{i_op(OP_ANDI, 12, 1, 16'hFF0F), 5'd12, 32'h0000_FF0B};
    vecs[13] = '{i_op(OP_ADDIU, 13, 2, 16'h8000),5'd13, 32'h1233_D678};
    vecs[14] = '{i_op(OP_LUI, 14, 0, 16'h7FFF),  5'd14, 32'h7FFF_0000};
    vecs[15] = '{r_op(6'h20, 15, 14, 14),        5'd15, 32'hFFFE_0000};
    vecs[16] = '{r_op(6'h2a, 16, 0, 1),          5'd16, 32'h0000_0000};
    vecs[17] = '{r_op(6'h2b, 17, 0, 1),          5'd17, 32'h0000_0001};
    vecs[18] = '{i_op(OP_ADDI, 0, 0, 16'h0007),  5'd0,  32'h0000_0000};
    vecs[19] = '{r_op(6'h20, 18, 0, 0),          5'd18, 32'h0000_0000};
    vecs[20] = '{r_op(6'h21, 19, 1, 1),          5'd19, 32'hFFFF_FFF6};

    cfs[0] = '{i_op(OP_BEQ, 0, 0, 16'hFFFF), 32'h0000_0040};
    cfs[1] = '{i_op(OP_BNE, 0, 0, 16'h0004), 32'h0000_0044};
    cfs[2] = '{j_op(26'h100),                32'h0000_0400};

    // Reset, first fetch, and reset asserted in the middle of FETCH
    prog.delete(); prog.push_back(i_op(OP_ADDI, 1, 0, 16'h1)); load_prog(1'b0);
    start_cpu();
    check("reset_pc", pc, 32'h0);
    @(negedge clock); #2;
    check("idle_mem_req", mem_req, 1'b0);
    check("idle_retire", retire, 1'b0);
    @(negedge clock); #2;
    check("fetch_mem_req", mem_req, 1'b1);
    check("fetch_mem_addr", mem_addr, 32'h0);
    check("fetch_mem_write", mem_write, 1'b0);
    nreset = 1'b0;
    #1;
    check("async_reset_mem_req", mem_req, 1'b0);
    check("async_reset_halted", halted, 1'b0);

    // ALU/immediate table, each result dumped by a following sw, then halt opcode 0x3F
    prog.delete();
    foreach (vecs[i]) begin
      prog.push_back(vecs[i].instr);
      prog.push_back(i_op(OP_SW, vecs[i].rd, 0, 16'(32'h800 + 4 * i)));
    end
    prog.push_back(HALT_INSTR);
    load_prog(1'b0);
    start_cpu();
    run_to_halt(1000, "alu_table");
    foreach (vecs[i]) check($sformatf("alu_vec%0d", i), mem[32'h200 + i], vecs[i].exp);
    check("alu_first_retire_cycle", retire_cyc[0], 32'd5);
    check("alu_retire_count", retire_cnt, 32'(2 * 21));
    check("alu_last_retire_cycle", last_retire, 32'(1 + 2 * 21 * 4));
    rc = req_cycles; pc_snap = pc;
    repeat (50) @(negedge clock);
    #2;
    check("halt_no_requests", req_cycles - rc, 32'd0);
    check("halt_pc_frozen", pc, 32'(4 * (2 * 21 + 1)));
    check("halt_still_halted", halted, 1'b1);

    // Store then load with three wait cycles per transaction
    wait_cycles = 3;
    prog.delete();
    prog.push_back(i_op(OP_LUI, 2, 0, 16'h1234));
    prog.push_back(i_op(OP_ORI, 2, 2, 16'h5678));
    prog.push_back(i_op(OP_SW, 2, 0, 16'h0008));
    prog.push_back(i_op(OP_LW, 5, 0, 16'h0008));
    prog.push_back(i_op(OP_SW, 5, 0, 16'h0800));
    prog.push_back(HALT_INSTR);
    load_prog(1'b0);
    start_cpu();
    run_to_halt(500, "mem_wait");
    check("wait_store_addr", st_addr_q[0], 32'h8);
    check("wait_store_data", st_data_q[0], 32'h1234_5678);
    check("wait_store_count", st_addr_q.size(), 32'd2);
    check("wait_lw_result", mem[32'h200], 32'h1234_5678);
    check("wait_sw_latency", retire_cyc[2] - retire_cyc[1], 32'd10);
    check("wait_lw_latency", retire_cyc[3] - retire_cyc[2], 32'd11);
    wait_cycles = 0;

    // Control flow: a j at 0 lands on the instruction under test at 0x40
    foreach (cfs[i]) begin
      int n = 0;
      prog.delete(); prog.push_back(j_op(26'h10)); load_prog(1'b0);
      mem[32'h10] = cfs[i].instr;
      start_cpu();
      while (reads.size() < 3 && n < 40) begin
        @(negedge clock);
        n++;
      end
      #2 check($sformatf("cf%0d_fetch_count", i), reads.size() >= 3, 1'b1);
      check($sformatf("cf%0d_next_fetch", i), reads[2], cfs[i].next_addr);
    end

    // Misaligned load: halts without a data request when checked, issues addr 2 when not
    prog.delete();
    prog.push_back(i_op(OP_LW, 1, 0, 16'h0002));
    prog.push_back(HALT_INSTR);
    load_prog(1'b0);
    start_cpu();
    repeat (30) @(negedge clock);
    #2;
    check("align_halted", halted, 1'b1);
    check("align_req_cycles", req_cycles, 32'd1);
    check("align_read_count", reads.size(), 32'd1);
    check("noalign_read_count", reads2.size(), 32'd3);
    check("noalign_data_addr", reads2[1], 32'h2);
    check("noalign_halted", halted2, 1'b1);

    // Randomized programs against the reference model
    for (int r = 0; r < 4; r++) begin
      wait_cycles = r % 3;
      gen_random(40);
      load_prog(1'b1);
      run_model(wait_cycles, n_ret, cyc_sum);
      start_cpu();
      run_to_halt(4000, $sformatf("rand%0d", r));
      for (int k = 1; k < 32; k++)
        check($sformatf("rand%0d_r%0d", r, k), mem[32'h200 + k], mr[k]);
      bad = 0;
      for (int w = 'h180; w < 'h1C0; w++) if (mem[w] !== mm[w]) bad++;
      check($sformatf("rand%0d_data_mismatch_words", r), bad, 32'd0);
      check($sformatf("rand%0d_retire_count", r), retire_cnt, n_ret);
      check($sformatf("rand%0d_last_retire_cycle", r), last_retire, 32'(1 + cyc_sum));
    end

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
